// File: rtl/accelerator_pkg.sv
// Shared types and encodings for the vector decoder and the PE array it feeds.
package accelerator_pkg;

  localparam logic [6:0] V_MAJOR_OP_V = 7'b1010111;

  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPFVV = 3'b001;
  localparam logic [2:0] F3_OPMVV = 3'b010;
  localparam logic [2:0] F3_OPIVI = 3'b011;
  localparam logic [2:0] F3_OPIVX = 3'b100;
  localparam logic [2:0] F3_OPFVF = 3'b101;
  localparam logic [2:0] F3_OPMVX = 3'b110;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  localparam logic [5:0] F6_VADD    = 6'b000000;
  localparam logic [5:0] F6_VSUB    = 6'b000010;
  localparam logic [5:0] F6_VMINU   = 6'b000100;
  localparam logic [5:0] F6_VMAXU   = 6'b000110;
  localparam logic [5:0] F6_VAND    = 6'b001001;
  localparam logic [5:0] F6_VOR     = 6'b001010;
  localparam logic [5:0] F6_VXOR    = 6'b001011;
  localparam logic [5:0] F6_VSADDU  = 6'b100000;
  localparam logic [5:0] F6_VSADD   = 6'b100001;
  localparam logic [5:0] F6_VSLL    = 6'b100101;
  localparam logic [5:0] F6_VSRL    = 6'b101000;
  localparam logic [5:0] F6_VSRA    = 6'b101001;
  localparam logic [5:0] F6_VMUL    = 6'b100101;
  localparam logic [5:0] F6_VMACC   = 6'b101101;
  localparam logic [5:0] F6_VREDSUM = 6'b000000;

  typedef enum logic [3:0] {
    PE_OP_ADD        = 4'd0,
    PE_OP_SUB        = 4'd1,
    PE_OP_AND        = 4'd2,
    PE_OP_OR         = 4'd3,
    PE_OP_XOR        = 4'd4,
    PE_OP_LSHIFT     = 4'd5,
    PE_OP_RSHIFT_LOG = 4'd6,
    PE_OP_RSHIFT_AR  = 4'd7,
    PE_OP_MUL        = 4'd8,
    PE_OP_MULADD     = 4'd9
  } pe_arith_op_t;

  typedef enum logic [1:0] {
    PE_OPERAND_VS1       = 2'd0,
    PE_OPERAND_SCALAR    = 2'd1,
    PE_OPERAND_IMMEDIATE = 2'd2,
    PE_OPERAND_RIPPLE    = 2'd3
  } pe_operand_t;

  typedef enum logic [1:0] {
    PE_SAT_NONE  = 2'd0,
    PE_SAT       = 2'd1,
    PE_SAT_UPPER = 2'd2
  } pe_saturation_mode_t;

  typedef enum logic [1:0] {
    PE_OP_MODE_RESULT   = 2'd0,
    PE_OP_MODE_PASS_MIN = 2'd1,
    PE_OP_MODE_PASS_MAX = 2'd2
  } pe_output_mode_t;

  typedef struct packed {
    pe_arith_op_t        arith;
    pe_operand_t         operand;
    pe_saturation_mode_t sat;
    pe_output_mode_t     outmode;
  } pe_ctrl_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } dec_state_t;

endpackage

// File: rtl/vec_decode_lut.sv
// Pure combinational funct3/funct6 -> PE control lookup for OP-V arithmetic.
module vec_decode_lut
  import accelerator_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [5:0] funct6,
  output pe_ctrl_t   ctrl,
  output logic       legal,
  output logic       shift_op
);

  always_comb begin
    ctrl     = '{arith: PE_OP_ADD, operand: PE_OPERAND_VS1,
                 sat: PE_SAT_NONE, outmode: PE_OP_MODE_RESULT};
    legal    = 1'b0;
    shift_op = 1'b0;
    case (funct3)
      F3_OPIVV, F3_OPIVX, F3_OPIVI: begin
        legal = 1'b1;
        if (funct3 == F3_OPIVX)      ctrl.operand = PE_OPERAND_SCALAR;
        else if (funct3 == F3_OPIVI) ctrl.operand = PE_OPERAND_IMMEDIATE;
        case (funct6)
          F6_VADD:   ctrl.arith = PE_OP_ADD;
          F6_VSUB:   ctrl.arith = PE_OP_SUB;
          F6_VAND:   ctrl.arith = PE_OP_AND;
          F6_VOR:    ctrl.arith = PE_OP_OR;
          F6_VXOR:   ctrl.arith = PE_OP_XOR;
          F6_VSLL:   begin ctrl.arith = PE_OP_LSHIFT;     shift_op = 1'b1; end
          F6_VSRL:   begin ctrl.arith = PE_OP_RSHIFT_LOG; shift_op = 1'b1; end
          F6_VSRA:   begin ctrl.arith = PE_OP_RSHIFT_AR;  shift_op = 1'b1; end
          F6_VMINU:  ctrl.outmode = PE_OP_MODE_PASS_MIN;
          F6_VMAXU:  ctrl.outmode = PE_OP_MODE_PASS_MAX;
          F6_VSADDU: ctrl.sat = PE_SAT_UPPER;
          F6_VSADD:  ctrl.sat = PE_SAT;
          default:   legal = 1'b0;
        endcase
      end
      F3_OPMVV, F3_OPMVX: begin
        legal = 1'b1;
        if (funct3 == F3_OPMVX) ctrl.operand = PE_OPERAND_SCALAR;
        case (funct6)
          F6_VMUL:  ctrl.arith = PE_OP_MUL;
          F6_VMACC: ctrl.arith = PE_OP_MULADD;
          // Reduction sums ripple partial results across the PE chain.
          F6_VREDSUM: begin
            if (funct3 == F3_OPMVV) ctrl.operand = PE_OPERAND_RIPPLE;
            else                    legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/vec_decoder.sv
// RISC-V vector instruction decoder: vsetvli handling and element-group micro-op issue.
module vec_decoder
  import accelerator_pkg::*;
#(
  parameter int VLEN   = 128,
  parameter int NUM_PE = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                instr_valid,
  input  logic [31:0]                         instr,
  input  logic [31:0]                         scalar_operand,
  output logic                                instr_ready,
  output logic                                uop_valid,
  input  logic                                uop_ready,
  output logic [3:0]                          uop_arith,
  output logic [1:0]                          uop_operand,
  output logic [1:0]                          uop_sat,
  output logic [1:0]                          uop_outmode,
  output logic [4:0]                          uop_vd,
  output logic [4:0]                          uop_vs1,
  output logic [4:0]                          uop_vs2,
  output logic [31:0]                         uop_data,
  output logic [$clog2(VLEN/8/NUM_PE)-1:0]    uop_group,
  output logic                                uop_last,
  output logic                                cfg_done,
  output logic [$clog2(VLEN/8):0]             cfg_vl,
  output logic                                illegal
);

  localparam int GW  = $clog2(VLEN/8/NUM_PE);
  localparam int VLW = $clog2(VLEN/8) + 1;

  dec_state_t     state, state_next;
  pe_ctrl_t       lut_ctrl, ctrl_q;
  logic           lut_legal, lut_shift;
  logic [2:0]     vsew;
  logic [GW-1:0]  last_group;
  logic [31:0]    data_next;
  logic [VLW-1:0] vlmax;
  logic           accept, is_opv, is_cfg, is_arith, launch;
  logic           unused_vsew;

  logic [6:0] opcode;
  logic [2:0] funct3, vsew_field;
  logic [5:0] funct6;
  logic [4:0] rs1, rd, vs2;

  function automatic logic [31:0] ext_imm(input logic [4:0] imm, input logic zext);
    return zext ? {27'b0, imm} : {{27{imm[4]}}, imm};
  endfunction

  function automatic logic [VLW-1:0] clamp_vl(input logic [31:0] avl, input logic [VLW-1:0] vmax);
    return (avl < 32'(vmax)) ? VLW'(avl) : vmax;
  endfunction

  function automatic logic [GW-1:0] last_group_of(input logic [VLW-1:0] vl);
    logic [VLW:0] groups;
    groups = ({1'b0, vl} + (VLW+1)'(NUM_PE - 1)) / (VLW+1)'(NUM_PE);
    return GW'(groups - (VLW+1)'(1));
  endfunction

  assign opcode     = instr[6:0];
  assign rd         = instr[11:7];
  assign funct3     = instr[14:12];
  assign rs1        = instr[19:15];
  assign vs2        = instr[24:20];
  assign vsew_field = instr[25:23];
  assign funct6     = instr[31:26];

  vec_decode_lut u_lut (
    .funct3   (funct3),
    .funct6   (funct6),
    .ctrl     (lut_ctrl),
    .legal    (lut_legal),
    .shift_op (lut_shift)
  );

  assign accept   = instr_valid && instr_ready;
  assign is_opv   = (opcode == V_MAJOR_OP_V);
  assign is_cfg   = is_opv && (funct3 == F3_OPCFG) && !instr[31] && (vsew_field <= 3'b010);
  assign is_arith = is_opv && lut_legal;
  // vl == 0 retires the instruction without entering ISSUE.
  assign launch   = accept && is_arith && (cfg_vl != '0);
  assign vlmax    = VLW'(VLEN/8) >> vsew_field;

  always_comb begin
    case (lut_ctrl.operand)
      PE_OPERAND_SCALAR:    data_next = scalar_operand;
      PE_OPERAND_IMMEDIATE: data_next = ext_imm(rs1, lut_shift);
      default:              data_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = ISSUE;
      ISSUE:   if (uop_ready && uop_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    uop_valid   = (state == ISSUE);
    uop_last    = (state == ISSUE) && (uop_group == last_group);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal    <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_vl     <= '0;
      vsew       <= '0;
      ctrl_q     <= '0;
      uop_vd     <= '0;
      uop_vs1    <= '0;
      uop_vs2    <= '0;
      uop_data   <= '0;
      uop_group  <= '0;
      last_group <= '0;
    end else begin
      illegal  <= accept && !is_cfg && !is_arith;
      cfg_done <= accept && is_cfg;
      if (accept && is_cfg) begin
        vsew <= vsew_field;
        if (rs1 != 5'd0)     cfg_vl <= clamp_vl(scalar_operand, vlmax);
        else if (rd != 5'd0) cfg_vl <= vlmax;
      end
      if (launch) begin
        ctrl_q     <= lut_ctrl;
        uop_vd     <= rd;
        uop_vs1    <= rs1;
        uop_vs2    <= vs2;
        uop_data   <= data_next;
        uop_group  <= '0;
        last_group <= last_group_of(cfg_vl);
      end else if ((state == ISSUE) && uop_ready) begin
        uop_group <= uop_last ? '0 : uop_group + GW'(1);
      end
    end
  end

  assign uop_arith   = ctrl_q.arith;
  assign uop_operand = ctrl_q.operand;
  assign uop_sat     = ctrl_q.sat;
  assign uop_outmode = ctrl_q.outmode;

  // Element width is held as architectural state; the PE array does not consume it yet.
  assign unused_vsew = ^vsew;

endmodule

// File: tb/tb_vec_decoder.sv
// Directed table-driven bench for vec_decoder plus stall and reset-in-flight sequences.
module tb_vec_decoder;
  import accelerator_pkg::*;

  logic        clk = 1'b0;
  logic        reset, instr_valid, uop_ready;
  logic [31:0] instr, scalar_operand;
  logic        instr_ready, uop_valid, uop_last, cfg_done, illegal;
  logic [3:0]  uop_arith;
  logic [1:0]  uop_operand, uop_sat, uop_outmode;
  logic [4:0]  uop_vd, uop_vs1, uop_vs2;
  logic [31:0] uop_data;
  logic [1:0]  uop_group;
  logic [4:0]  cfg_vl;

  int n_tests = 0;
  int n_fail  = 0;

  vec_decoder #(.VLEN(128), .NUM_PE(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .scalar_operand(scalar_operand), .instr_ready(instr_ready), .uop_valid(uop_valid),
    .uop_ready(uop_ready), .uop_arith(uop_arith), .uop_operand(uop_operand),
    .uop_sat(uop_sat), .uop_outmode(uop_outmode), .uop_vd(uop_vd), .uop_vs1(uop_vs1),
    .uop_vs2(uop_vs2), .uop_data(uop_data), .uop_group(uop_group), .uop_last(uop_last),
    .cfg_done(cfg_done), .cfg_vl(cfg_vl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] scalar;
    logic        ill;
    logic        cfg;
    logic [4:0]  vl;
    int          nuops;
    logic [3:0]  arith;
    logic [1:0]  operand;
    logic [1:0]  sat;
    logic [1:0]  outm;
    logic [31:0] data;
    logic [4:0]  vd, vs1, vs2;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] opv(input logic [5:0] f6, input logic [4:0] vs2,
                                      input logic [4:0] vs1, input logic [2:0] f3,
                                      input logic [4:0] vd);
    return {f6, 1'b1, vs2, vs1, f3, vd, 7'b1010111};
  endfunction

  function automatic logic [31:0] vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [2:0] sew);
    return {1'b0, 5'b0, sew, 3'b000, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] ins, input logic [31:0] sc,
                              input logic ill, input logic cfg, input logic [4:0] vl,
                              input int n, input logic [3:0] ar, input logic [1:0] op,
                              input logic [1:0] sa, input logic [1:0] om, input logic [31:0] d,
                              input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
    vec_t v;
    v.name = nm; v.instr = ins; v.scalar = sc; v.ill = ill; v.cfg = cfg; v.vl = vl;
    v.nuops = n; v.arith = ar; v.operand = op; v.sat = sa; v.outm = om; v.data = d;
    v.vd = vd; v.vs1 = vs1; v.vs2 = vs2;
    return v;
  endfunction

  function automatic vec_t mk_ctl(input string nm, input logic [31:0] ins, input logic [31:0] sc,
                                  input logic ill, input logic cfg, input logic [4:0] vl);
    return mk(nm, ins, sc, ill, cfg, vl, 0, 4'd0, 2'd0, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0, 5'd0);
  endfunction

  task automatic check_uop(input vec_t v, input int g);
    check({v.name, ".valid"}, uop_valid, 1);
    check({v.name, ".group"}, uop_group, g);
    check({v.name, ".last"}, uop_last, (g == v.nuops - 1));
    check({v.name, ".arith"}, uop_arith, v.arith);
    check({v.name, ".operand"}, uop_operand, v.operand);
    check({v.name, ".sat"}, uop_sat, v.sat);
    check({v.name, ".outmode"}, uop_outmode, v.outm);
    check({v.name, ".data"}, uop_data, v.data);
    check({v.name, ".vd"}, uop_vd, v.vd);
    check({v.name, ".vs1"}, uop_vs1, v.vs1);
    check({v.name, ".vs2"}, uop_vs2, v.vs2);
  endtask

  // Offers one instruction; returns at the negedge right after the accepting edge.
  task automatic offer(input vec_t v);
    @(negedge clk);
    instr_valid = 1'b1; instr = v.instr; scalar_operand = v.scalar;
    check({v.name, ".instr_ready"}, instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    offer(v);
    check({v.name, ".illegal"}, illegal, v.ill);
    check({v.name, ".cfg_done"}, cfg_done, v.cfg);
    check({v.name, ".cfg_vl"}, cfg_vl, v.vl);
    check({v.name, ".busy"}, instr_ready, (v.nuops == 0));
    for (int k = 0; k < v.nuops; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
        if (k == 1) begin
          check({v.name, ".illegal_pulse"}, illegal, 0);
          check({v.name, ".cfg_done_pulse"}, cfg_done, 0);
        end
      end
      check_uop(v, k);
    end
    @(posedge clk);
    @(negedge clk);
    check({v.name, ".end_illegal"}, illegal, 0);
    check({v.name, ".end_cfg_done"}, cfg_done, 0);
    check({v.name, ".end_valid"}, uop_valid, 0);
    check({v.name, ".end_ready"}, instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t st, rs;
    reset = 1'b1; instr_valid = 1'b0; instr = '0; scalar_operand = '0; uop_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.instr_ready", instr_ready, 1);
    check("reset.uop_valid", uop_valid, 0);
    check("reset.uop_last", uop_last, 0);
    check("reset.uop_group", uop_group, 0);
    check("reset.cfg_vl", cfg_vl, 0);
    check("reset.cfg_done", cfg_done, 0);
    check("reset.illegal", illegal, 0);
    check("reset.uop_data", uop_data, 0);
    check("reset.uop_arith", uop_arith, 0);
    reset = 1'b0;

    tbl.push_back(mk_ctl("vsetvli_e8_20", vsetvli(5'd1, 5'd5, 3'b000), 32'd20, 0, 1, 5'd16));
    tbl.push_back(mk("vadd_vv", opv(6'b000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'hCAFE, 0, 0, 5'd16, 4,
                     PE_OP_ADD, PE_OPERAND_VS1, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'h0, 5'd3, 5'd1, 5'd2));
    tbl.push_back(mk("vadd_vi", opv(6'b000000, 5'd5, 5'b11110, 3'b011, 5'd4), 32'hDEADBEEF, 0, 0, 5'd16, 4,
                     PE_OP_ADD, PE_OPERAND_IMMEDIATE, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'hFFFFFFFE, 5'd4, 5'd30, 5'd5));
    tbl.push_back(mk("vsll_vi", opv(6'b100101, 5'd6, 5'b11110, 3'b011, 5'd7), 32'h0, 0, 0, 5'd16, 4,
                     PE_OP_LSHIFT, PE_OPERAND_IMMEDIATE, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'h0000001E, 5'd7, 5'd30, 5'd6));
    tbl.push_back(mk("vsub_vx", opv(6'b000010, 5'd9, 5'd10, 3'b100, 5'd8), 32'h12345678, 0, 0, 5'd16, 4,
                     PE_OP_SUB, PE_OPERAND_SCALAR, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'h12345678, 5'd8, 5'd10, 5'd9));
    tbl.push_back(mk("vsaddu_vv", opv(6'b100000, 5'd12, 5'd11, 3'b000, 5'd13), 32'h0, 0, 0, 5'd16, 4,
                     PE_OP_ADD, PE_OPERAND_VS1, PE_SAT_UPPER, PE_OP_MODE_RESULT, 32'h0, 5'd13, 5'd11, 5'd12));
    tbl.push_back(mk("vmul_vx", opv(6'b100101, 5'd14, 5'd15, 3'b110, 5'd16), 32'hFFFF0001, 0, 0, 5'd16, 4,
                     PE_OP_MUL, PE_OPERAND_SCALAR, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'hFFFF0001, 5'd16, 5'd15, 5'd14));
    tbl.push_back(mk("vredsum", opv(6'b000000, 5'd17, 5'd18, 3'b010, 5'd19), 32'h77, 0, 0, 5'd16, 4,
                     PE_OP_ADD, PE_OPERAND_RIPPLE, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'h0, 5'd19, 5'd18, 5'd17));
    tbl.push_back(mk("vminu_vv", opv(6'b000100, 5'd20, 5'd21, 3'b000, 5'd22), 32'h0, 0, 0, 5'd16, 4,
                     PE_OP_ADD, PE_OPERAND_VS1, PE_SAT_NONE, PE_OP_MODE_PASS_MIN, 32'h0, 5'd22, 5'd21, 5'd20));
    tbl.push_back(mk_ctl("vsetvli_e32_3", vsetvli(5'd2, 5'd7, 3'b010), 32'd3, 0, 1, 5'd3));
    tbl.push_back(mk("vxor_vv_vl3", opv(6'b001011, 5'd1, 5'd2, 3'b000, 5'd3), 32'h0, 0, 0, 5'd3, 1,
                     PE_OP_XOR, PE_OPERAND_VS1, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'h0, 5'd3, 5'd2, 5'd1));
    tbl.push_back(mk_ctl("vsetvli_e16_max", vsetvli(5'd1, 5'd0, 3'b001), 32'h55, 0, 1, 5'd8));
    tbl.push_back(mk("vsra_vi", opv(6'b101001, 5'd4, 5'b11111, 3'b011, 5'd5), 32'h0, 0, 0, 5'd8, 2,
                     PE_OP_RSHIFT_AR, PE_OPERAND_IMMEDIATE, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'h0000001F, 5'd5, 5'd31, 5'd4));
    tbl.push_back(mk_ctl("vsetvli_keep", vsetvli(5'd0, 5'd0, 3'b000), 32'd2, 0, 1, 5'd8));
    tbl.push_back(mk("vor_vv_vl8", opv(6'b001010, 5'd6, 5'd7, 3'b000, 5'd8), 32'h0, 0, 0, 5'd8, 2,
                     PE_OP_OR, PE_OPERAND_VS1, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'h0, 5'd8, 5'd7, 5'd6));
    tbl.push_back(mk_ctl("vsetvli_e64_bad", vsetvli(5'd1, 5'd5, 3'b011), 32'd9, 1, 0, 5'd8));
    tbl.push_back(mk("vmacc_vx", opv(6'b101101, 5'd3, 5'd4, 3'b110, 5'd5), 32'd7, 0, 0, 5'd8, 2,
                     PE_OP_MULADD, PE_OPERAND_SCALAR, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'd7, 5'd5, 5'd4, 5'd3));
    tbl.push_back(mk_ctl("vsetvli_e32_clamp", vsetvli(5'd1, 5'd5, 3'b010), 32'h100, 0, 1, 5'd4));
    tbl.push_back(mk("vsrl_vx_vl4", opv(6'b101000, 5'd1, 5'd2, 3'b100, 5'd3), 32'h5, 0, 0, 5'd4, 1,
                     PE_OP_RSHIFT_LOG, PE_OPERAND_SCALAR, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'h5, 5'd3, 5'd2, 5'd1));
    tbl.push_back(mk_ctl("vsetvli_zero", vsetvli(5'd1, 5'd5, 3'b000), 32'd0, 0, 1, 5'd0));
    tbl.push_back(mk_ctl("vadd_vx_vl0", opv(6'b000000, 5'd1, 5'd2, 3'b100, 5'd3), 32'h9, 0, 0, 5'd0));
    tbl.push_back(mk_ctl("funct6_111111", opv(6'b111111, 5'd1, 5'd2, 3'b000, 5'd3), 32'h0, 1, 0, 5'd0));
    tbl.push_back(mk_ctl("bad_opcode", 32'h002081B3, 32'h0, 1, 0, 5'd0));
    tbl.push_back(mk_ctl("opfvv", opv(6'b000000, 5'd1, 5'd2, 3'b001, 5'd3), 32'h0, 1, 0, 5'd0));
    tbl.push_back(mk_ctl("vsetvl_form", 32'h80000000 | vsetvli(5'd1, 5'd5, 3'b000), 32'd4, 1, 0, 5'd0));
    tbl.push_back(mk_ctl("vredsum_vx", opv(6'b000000, 5'd1, 5'd2, 3'b110, 5'd3), 32'h0, 1, 0, 5'd0));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Back-pressure: hold uop_ready low for three cycles at group 1.
    run_vec(mk_ctl("stall.vsetvli", vsetvli(5'd1, 5'd5, 3'b000), 32'd16, 0, 1, 5'd16));
    st = mk("stall.vand_vx", opv(6'b001001, 5'd6, 5'd9, 3'b100, 5'd7), 32'hA5A5, 0, 0, 5'd16, 4,
            PE_OP_AND, PE_OPERAND_SCALAR, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'hA5A5, 5'd7, 5'd9, 5'd6);
    offer(st);
    check_uop(st, 0);
    @(posedge clk);
    @(negedge clk);
    uop_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_uop(st, 1);
      @(posedge clk);
      @(negedge clk);
    end
    uop_ready = 1'b1;
    for (int g = 1; g < 4; g++) begin
      check_uop(st, g);
      @(posedge clk);
      @(negedge clk);
    end
    check("stall.end_valid", uop_valid, 0);
    check("stall.end_ready", instr_ready, 1);

    // Reset while group 2 is on offer abandons the instruction and clears vl.
    rs = mk("rst.vadd_vv", opv(6'b000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 0, 0, 5'd16, 4,
            PE_OP_ADD, PE_OPERAND_VS1, PE_SAT_NONE, PE_OP_MODE_RESULT, 32'h0, 5'd3, 5'd1, 5'd2);
    offer(rs);
    for (int g = 0; g < 2; g++) begin
      check_uop(rs, g);
      @(posedge clk);
      @(negedge clk);
    end
    check("rst.group_before", uop_group, 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst.uop_valid", uop_valid, 0);
    check("rst.cfg_vl", cfg_vl, 0);
    check("rst.instr_ready", instr_ready, 1);
    check("rst.uop_group", uop_group, 0);
    check("rst.uop_last", uop_last, 0);
    check("rst.uop_vd", uop_vd, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst.still_idle", uop_valid, 0);
    run_vec(mk_ctl("rst.vadd_vl0", opv(6'b000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 0, 0, 5'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_decoder.md
VEC_DECODER -- requirements
Module: vec_decoder

Interface
REQ-001 Parameter VLEN, default 128, vector register length in bits.
REQ-002 Parameter NUM_PE, default 4, elements processed per micro-op (element group).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr_valid  input  1  host core offers a 32-bit instruction.
REQ-006 instr  input  32  raw RISC-V instruction word.
REQ-007 scalar_operand  input  32  rs1 value, valid with instr_valid.
REQ-008 instr_ready  output  1  decoder accepts instruction this cycle.
REQ-009 uop_valid  output  1  micro-op presented to the PE array.
REQ-010 uop_ready  input  1  PE array consumes micro-op.
REQ-011 uop_arith  output  4  pe_arith_op_t; uop_operand  output  2  pe_operand_t; uop_sat  output  2  pe_saturation_mode_t; uop_outmode  output  2  pe_output_mode_t.
REQ-012 uop_vd, uop_vs1, uop_vs2  output  5 each  register specifiers.
REQ-013 uop_data  output  32  scalar operand or extended immediate.
REQ-014 uop_group  output  $clog2(VLEN/8/NUM_PE)  element-group index; uop_last  output  1  final group of instruction.
REQ-015 cfg_done  output  1  one-cycle pulse when vl is updated; cfg_vl  output  $clog2(VLEN/8)+1  current vl.
REQ-016 illegal  output  1  one-cycle pulse for an unsupported instruction.

Function
REQ-017 The FSM SHALL have states IDLE and ISSUE; instr_ready SHALL equal 1 only in IDLE; accept = instr_valid && instr_ready.
REQ-018 Decoding: opcode 1010111 maps to V_MAJOR_OP_V; any other opcode, or an unlisted funct3/funct6, SHALL pulse illegal the cycle after accept and remain in IDLE.
REQ-019 OPIVV/OPIVX/OPIVI funct6: 000000 ADD; 000010 SUB; 001001 AND; 001010 OR; 001011 XOR; 100101 LSHIFT; 101000 RSHIFT_LOG; 101001 RSHIFT_AR; 000100 ADD+PASS_MIN; 000110 ADD+PASS_MAX; 100000 ADD+SAT_UPPER; 100001 ADD+SAT. All others: PE_SAT_NONE, PE_OP_MODE_RESULT.
REQ-020 OPMVV/OPMVX funct6: 100101 MUL; 101101 MULADD; OPMVV 000000 (vredsum) ADD with PE_OPERAND_RIPPLE.
REQ-021 Operand select: VV gives VS1 (uop_data=0); VX gives SCALAR (uop_data=scalar_operand); VI gives IMMEDIATE, with simm5 sign-extended, except shift ops, which zero-extend uimm5.
REQ-022 OPCFG (vsetvli, instr[31]=0): vsew=instr[25:23]; 000/001/010 legal, others illegal. VLMAX=VLEN/(8<<vsew); vl=min(scalar_operand, VLMAX); if rs1=x0 and rd!=x0, vl=VLMAX; if rs1=x0 and rd=x0, vl unchanged. cfg_vl SHALL update and cfg_done SHALL pulse one cycle after accept.
REQ-023 A legal arithmetic op with vl=0 SHALL be accepted, retire silently, and stay in IDLE.
REQ-024 A legal arithmetic op with vl>0 SHALL register all fields, enter ISSUE the next cycle with uop_group=0, and issue ceil(vl/NUM_PE) micro-ops.
REQ-025 In ISSUE, uop_valid=1; on uop_ready, uop_group increments; uop_last=1 when uop_group=ceil(vl/NUM_PE)-1; consuming last returns to IDLE the following cycle.
REQ-026 While uop_valid && !uop_ready, all uop_* outputs SHALL hold stable.
REQ-027 vl changes only in IDLE, so an in-flight instruction always uses the vl latched at accept.

Reset
REQ-028 When reset is high at a clock edge, the next state SHALL be: IDLE, uop_valid=0, uop_group=0, uop_last=0, illegal=0, cfg_done=0, cfg_vl=0, vsew=000, all uop fields 0.
REQ-029 Reset during ISSUE SHALL abandon the instruction; no further micro-ops are issued.

Structure
REQ-030 accelerator_pkg SHALL gain the funct6 constants, the OP-V opcode constant, a pe_ctrl_t struct (arith, operand, sat, outmode), and the state enum.
REQ-031 The combinational funct3/funct6-to-pe_ctrl_t mapping SHALL be the sub-module vec_decode_lut; vec_decoder holds the FSM, vl/vsew registers, and the group counter.

Verification
REQ-032 vsetvli sew=8, rs1=x5=20 (VLEN 128) -> cfg_vl=16, one cfg_done pulse, no uop.
REQ-033 vl=16, vadd.vv v3,v1,v2 -> 4 uops, groups 0..3, uop_last only on group 3, ADD/VS1, vd=3, vs1=1, vs2=2.
REQ-034 vadd.vi simm5=11110 -> uop_data=0xFFFFFFFE; vsll.vi uimm5=11110 -> uop_data=0x0000001E, LSHIFT.
REQ-035 uop_ready low for 3 cycles at group 1 -> outputs constant; groups 1,2,3 then follow with none skipped.
REQ-036 vl=0 vadd.vx -> accepted, zero uops; funct6 111111 -> illegal pulse, instr_ready stays 1.
REQ-037 reset in ISSUE at group 2 -> uop_valid=0 and cfg_vl=0 next cycle, instr_ready=1.
